// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential multiplier.
// Contents:
//   mul_state_e  - multiplier FSM states
//   booth_op_e   - radix-2 Booth step operation
//   MUL_WIDTH, MUL_ITERS, COUNT_W - datapath sizing constants
//   prod_overflow() - 64-bit product does not fit in 32 signed bits
package alu_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;
  localparam int COUNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  // A product fits in 32 signed bits only if bits 63..31 are a pure sign extension.
  function automatic logic prod_overflow(input logic [63:0] p);
    return (p[63:31] != {33{1'b0}}) && (p[63:31] != {33{1'b1}});
  endfunction

endpackage

// File: rtl/add_32.sv
// 32-bit ripple-free behavioural adder with carry in and carry out.
// Ports:
//   a_i, b_i    - 32-bit addends
//   carry_in_i  - carry into bit 0
//   sum_o       - 32-bit sum
//   carry_o     - carry out of bit 31
module add_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_in_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);

  // Full 33-bit addition; the top bit is the unsigned carry out.
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, carry_in_i};

endmodule

// File: rtl/mul_32_booth.sv
// Sequential signed 32x32 -> 64 multiplier, radix-2 Booth, one step per cycle.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   in_valid / in_ready    - operand handshake (a = multiplicand, b = multiplier)
//   out_valid / out_ready  - result handshake
//   o_product              - signed 64-bit product {A,Q}
//   o_overflow             - product not representable in 32 signed bits
// Only one operation is in flight; IDLE is always visited between operations.
module mul_32_booth
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int ITERS = MUL_ITERS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_overflow
);

  mul_state_e               state_q;
  logic [WIDTH-1:0]         acc_q;      // A: upper half of the running product
  logic [WIDTH-1:0]         mlt_q;      // Q: multiplier, shifted out as product low half
  logic [WIDTH-1:0]         mcand_q;    // M: multiplicand
  logic                     qm1_q;      // q_{-1} Booth history bit
  logic [COUNT_W-1:0]       count_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [2*WIDTH-1:0]       product_q;
  logic                     overflow_q;

  booth_op_e                op_s;
  logic [WIDTH-1:0]         beff_s;
  logic                     cin_s;
  logic [WIDTH-1:0]         add_sum_s;
  logic                     add_carry_s;
  logic [WIDTH-1:0]         sum_s;
  logic                     shift_in_s;
  logic [WIDTH-1:0]         acc_d;
  logic [WIDTH-1:0]         mlt_d;
  logic                     qm1_d;

  add_32 u_add (
    .a_i        (acc_q),
    .b_i        (beff_s),
    .carry_in_i (cin_s),
    .sum_o      (add_sum_s),
    .carry_o    (add_carry_s)
  );

  // Booth decode, adder operand selection and the next shifted {A,Q,q_m1}.
  always_comb begin
    op_s = BOOTH_NOP;
    case ({mlt_q[0], qm1_q})
      2'b01:   op_s = BOOTH_ADD;
      2'b10:   op_s = BOOTH_SUB;
      default: op_s = BOOTH_NOP;
    endcase

    if (op_s == BOOTH_SUB) begin
      beff_s = ~mcand_q;
      cin_s  = 1'b1;
    end else begin
      beff_s = mcand_q;
      cin_s  = 1'b0;
    end

    // The shifted-in bit is the true 33rd (sign) bit of A +/- M, not sum[31]:
    // a31 ^ beff31 ^ carry reconstructs it even when the 32-bit result overflows,
    // which is what makes M = 0x80000000 come out right.
    if (op_s == BOOTH_NOP) begin
      sum_s      = acc_q;
      shift_in_s = acc_q[WIDTH-1];
    end else begin
      sum_s      = add_sum_s;
      shift_in_s = acc_q[WIDTH-1] ^ beff_s[WIDTH-1] ^ add_carry_s;
    end

    acc_d = {shift_in_s, sum_s[WIDTH-1:1]};
    mlt_d = {sum_s[0], mlt_q[WIDTH-1:1]};
    qm1_d = mlt_q[0];
  end

  // Control FSM with datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mlt_q       <= '0;
      mcand_q     <= '0;
      qm1_q       <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q    <= a;
            mlt_q      <= b;
            acc_q      <= '0;
            qm1_q      <= 1'b0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          mlt_q   <= mlt_d;
          qm1_q   <= qm1_d;
          count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
          if (count_q == COUNT_W'(ITERS - 1)) begin
            // Capture the final step's result directly so out_valid lands one cycle later.
            product_q   <= {acc_d, mlt_d};
            overflow_q  <= prod_overflow({acc_d, mlt_d});
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign o_product  = product_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_mul_32_booth.sv
// Self-checking bench for mul_32_booth using a result scoreboard.
module tb_mul_32_booth;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] o_product;
  logic        o_overflow;

  typedef struct {
    logic [63:0] p;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  mul_32_booth dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .o_product  (o_product),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive operands, push the expected result, return just after the accept edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] ep, input logic eo);
    exp_t e;
    int   n;
    e.p = ep;
    e.ovf = eo;
    sb_q.push_back(e);
    a = x;
    b = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("accept_timeout", 64'(n), 64'd0);
    tick();
    in_valid = 1'b0;
    // Operands must already be captured; scramble them.
    a = $urandom;
    b = $urandom;
  endtask

  // Wait for out_valid, check latency and compare against the scoreboard head.
  task automatic wait_result();
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd32);
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check("product", o_product, e.p);
      check("overflow", 64'(o_overflow), 64'(e.ovf));
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [63:0] model_p(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    return 64'(sx * sy);
  endfunction

  function automatic logic model_ovf(input logic [63:0] p);
    return (p[63:31] != {33{1'b0}}) && (p[63:31] != {33{1'b1}});
  endfunction

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] held;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", o_product, 64'd0);
    check("rst_overflow", 64'(o_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed cases with hand-computed results.
    start_op(32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b0);
    wait_result();
    consume();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    wait_result();
    consume();
    start_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    wait_result();
    consume();
    start_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b1);
    wait_result();
    consume();
    start_op(32'h0000_0000, 32'h1234_5678, 64'h0, 1'b0);
    wait_result();
    consume();

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = (i < 3) ? $urandom : {{16{x[15]}}, x[15:0]};
      start_op(x, y, model_p(x, y), model_ovf(model_p(x, y)));
      wait_result();
      consume();
    end

    // Backpressure: product held, no accept, second request ignored while DONE.
    start_op(32'hFFFF_FFF9, 32'd9, 64'hFFFF_FFFF_FFFF_FFC1, 1'b0);
    wait_result();
    held = o_product;
    a = 32'd11;
    b = 32'd13;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_product", o_product, 64'hFFFF_FFFF_FFFF_FFC1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp_idle_in_ready", 64'(in_ready), 64'd1);
    check("bp_idle_out_valid", 64'(out_valid), 64'd0);
    repeat (40) tick();
    check("bp_no_spurious", 64'(out_valid), 64'd0);
    check("bp_product_kept", o_product, held);

    // Asynchronous reset in the middle of an operation.
    start_op(32'd5, 32'd7, 64'd35, 1'b0);
    repeat (15) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_product", o_product, 64'd0);
    check("mid_rst_overflow", 64'(o_overflow), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_op(32'd6, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    wait_result();
    consume();

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
